// File: rtl/key_event_arbiter.sv
// Key event arbiter: per-key press/long/repeat/release detection,
// pending-flag queueing and round-robin event output.
module key_event_arbiter #(
  parameter int          NUM_KEYS   = 4,
  parameter logic [25:0] LONG_CNT   = 26'd25000000,
  parameter logic [25:0] REPEAT_CNT = 26'd5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2:0]          evt_key,
  output logic [1:0]          evt_type,
  output logic                ovf,
  input  logic                ovf_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } key_state_t;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  localparam logic [25:0] LONG_TC = LONG_CNT - 26'd1;
  localparam logic [25:0] REP_TC  = REPEAT_CNT - 26'd1;

  key_state_t            state_q [NUM_KEYS];
  key_state_t            state_d [NUM_KEYS];
  logic [25:0]           cnt_q   [NUM_KEYS];
  logic [25:0]           cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0]   prev_q;

  // Pending flags, bit index = event type code.
  logic [3:0]            pend_q  [NUM_KEYS];
  logic [3:0]            pend_d  [NUM_KEYS];
  logic [3:0]            set_flag[NUM_KEYS];
  logic [3:0]            hit     [NUM_KEYS];

  logic [2:0]            ptr_q;
  logic                  gnt_valid;
  logic [2:0]            gnt_key;
  logic [1:0]            gnt_type;
  logic [3:0]            gnt_pend;
  logic                  load;
  logic                  take;
  logic                  drop;

  // Per-key FSM next state, counter and event detection.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      set_flag[i] = 4'b0000;
      unique case (state_q[i])
        S_IDLE: begin
          if (prev_q[i] && !key_level[i]) begin
            set_flag[i][EV_PRESS] = 1'b1;
            state_d[i]            = S_PRESSED;
            cnt_d[i]              = 26'd0;
          end
        end
        S_PRESSED: begin
          if (!prev_q[i] && key_level[i]) begin
            set_flag[i][EV_RELEASE] = 1'b1;
            state_d[i]              = S_IDLE;
            cnt_d[i]                = 26'd0;
          end else if (!key_level[i]) begin
            if (cnt_q[i] == LONG_TC) begin
              set_flag[i][EV_LONG] = 1'b1;
              state_d[i]           = S_HELD;
              cnt_d[i]             = 26'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 26'd1;
            end
          end
        end
        S_HELD: begin
          if (!prev_q[i] && key_level[i]) begin
            set_flag[i][EV_RELEASE] = 1'b1;
            state_d[i]              = S_IDLE;
            cnt_d[i]                = 26'd0;
          end else if (!key_level[i]) begin
            if (cnt_q[i] == REP_TC) begin
              set_flag[i][EV_REPEAT] = 1'b1;
              cnt_d[i]               = 26'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 26'd1;
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = 26'd0;
        end
      endcase
    end
  end

  // Per-key FSM, counter and previous-level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 26'd0;
      end
      prev_q <= '1;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_q <= key_level;
    end
  end

  // Round-robin key pick starting after the last granted key.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_key   = 3'd0;
    gnt_pend  = 4'b0000;
    idx       = 0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_KEYS;
      if (!gnt_valid && (|pend_q[idx])) begin
        gnt_valid = 1'b1;
        gnt_key   = 3'(idx);
        gnt_pend  = pend_q[idx];
      end
    end
  end

  // Within the chosen key: press > long > repeat > release.
  always_comb begin
    if (gnt_pend[EV_PRESS]) begin
      gnt_type = EV_PRESS;
    end else if (gnt_pend[EV_LONG]) begin
      gnt_type = EV_LONG;
    end else if (gnt_pend[EV_REPEAT]) begin
      gnt_type = EV_REPEAT;
    end else begin
      gnt_type = EV_RELEASE;
    end
  end

  assign load = !evt_valid || evt_ready;
  assign take = load && gnt_valid;

  // Pending flag update; a new set beats a same-edge grant.
  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      for (int t = 0; t < 4; t++) begin
        hit[i][t] = take && (gnt_key == 3'(i)) &&
                    (gnt_type == 2'(t));
        pend_d[i][t] = set_flag[i][t] |
                       (pend_q[i][t] & ~hit[i][t]);
        if (set_flag[i][t] && pend_q[i][t] && !hit[i][t]) begin
          drop = 1'b1;
        end
      end
    end
  end

  // Pending flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        pend_q[i] <= 4'b0000;
      end
      ovf <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_key   <= 3'd0;
      evt_type  <= 2'd0;
      ptr_q     <= 3'(NUM_KEYS - 1);
    end else if (load) begin
      evt_valid <= gnt_valid;
      if (gnt_valid) begin
        evt_key  <= gnt_key;
        evt_type <= gnt_type;
        ptr_q    <= gnt_key;
      end
    end
  end

endmodule
